addsub_nibble_seq: RTL and testbench

//   Multi-precision add/subtract sequencer. Performs a NIBBLES*4-bit add or subtract
//   by passing one 4-bit slice per clock through a single shared ripple add/sub slice.

---
 rtl/addsub_nibble_seq_pkg.sv | 16 +
 rtl/addsub_nibble_seq_if.sv | 33 +++
 rtl/addsub_nibble_seq_slice.sv | 40 ++++
 rtl/addsub_nibble_seq.sv | 134 +++++++++++++
 tb/tb_addsub_nibble_seq.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/addsub_nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
// Optional signed-overflow flag is enabled by defining ADDSUB_VFLAG_EN.
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage

// File: rtl/addsub_nibble_seq_if.sv
// Requester-side bundle of the add/sub sequencer (start/ready handshake plus operands/results).
// The v flag exists only when ADDSUB_VFLAG_EN is defined.
interface addsub_nibble_seq_if #(parameter int W = 16);

  logic         start;
  logic         m;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
`ifdef ADDSUB_VFLAG_EN
  logic         v;
`endif

  modport master (
    output start, m, a, b,
    input  ready, done, result, cout
`ifdef ADDSUB_VFLAG_EN
    , input v
`endif
  );

  modport slave (
    input  start, m, a, b,
    output ready, done, result, cout
`ifdef ADDSUB_VFLAG_EN
    , output v
`endif
  );

endinterface

// File: rtl/addsub_nibble_seq_slice.sv
// Combinational 4-bit ripple add/subtract slice shared by every nibble of an operation.
// The carry-into-bit-3 tap (c3) is exported only when ADDSUB_VFLAG_EN is defined.
module nibble_addsub
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                m,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
`ifdef ADDSUB_VFLAG_EN
  , output logic              c3
`endif
);

  logic [NIBBLE_W-1:0] y_inv;

  assign y_inv = y ^ {NIBBLE_W{m}};

`ifdef ADDSUB_VFLAG_EN
  logic [3:0] low_sum;
  logic [1:0] top_sum;

  // Split at bit 3 so the carry into the sign bit is visible for overflow detection.
  always_comb begin
    low_sum = {1'b0, x[2:0]} + {1'b0, y_inv[2:0]} + {3'b000, cin};
    top_sum = {1'b0, x[3]} + {1'b0, y_inv[3]} + {1'b0, low_sum[3]};
    s       = {top_sum[0], low_sum[2:0]};
    co      = top_sum[1];
    c3      = low_sum[3];
  end
`else
  // Plain 4-bit ripple sum with carry out.
  always_comb begin
    {co, s} = {1'b0, x} + {1'b0, y_inv} + {4'b0000, cin};
  end
`endif

endmodule

// File: rtl/addsub_nibble_seq.sv
// Multi-precision add/subtract sequencer: one nibble per clock through a single shared slice.
// Define ADDSUB_VFLAG_EN to add the signed-overflow flag v.
module addsub_nibble_seq
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  addsub_nibble_seq_if.slave bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               m_q, m_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       result_q, result_d;
  logic               cout_q, cout_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [NIBBLE_W-1:0] sum_s;
  logic               co_s;
`ifdef ADDSUB_VFLAG_EN
  logic               c3_s;
  logic               v_q, v_d;
`endif

  nibble_addsub u_slice (
    .x   (a_q[{idx_q, 2'b00} +: NIBBLE_W]),
    .y   (b_q[{idx_q, 2'b00} +: NIBBLE_W]),
    .m   (m_q),
    .cin (carry_q),
    .s   (sum_s),
    .co  (co_s)
`ifdef ADDSUB_VFLAG_EN
    , .c3 (c3_s)
`endif
  );

  // Next-state and datapath updates; ready/done are decoded from the next state so they are registered.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    m_d      = m_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef ADDSUB_VFLAG_EN
    v_d      = v_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          m_d     = bus.m;
          carry_d = bus.m;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d[{idx_q, 2'b00} +: NIBBLE_W] = sum_s;
        carry_d = co_s;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = co_s;
`ifdef ADDSUB_VFLAG_EN
          v_d     = co_s ^ c3_s;
`endif
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      m_q      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef ADDSUB_VFLAG_EN
      v_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      m_q      <= m_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
`ifdef ADDSUB_VFLAG_EN
      v_q      <= v_d;
`endif
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
`ifdef ADDSUB_VFLAG_EN
  assign bus.v      = v_q;
`endif

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Self-checking bench for addsub_nibble_seq (NIBBLES=4): directed vector table plus
// multi-cycle sequences for held start and mid-operation reset.
module tb_addsub_nibble_seq;

  localparam int NIB = 4;
  localparam int W   = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  addsub_nibble_seq_if #(.W(W)) bus ();

  addsub_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         cout;
    logic         v;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op from an IDLE cycle (called at posedge+1) and check latency and results.
  task automatic run_op(input vec_t vv, input string tag);
    int n;
    check({tag, " ready"}, {31'd0, bus.ready}, 32'd1);
    bus.start = 1'b1;
    bus.m = vv.m;
    bus.a = vv.a;
    bus.b = vv.b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = ~vv.a;
    bus.b = vv.a ^ 16'h5A5A;
    bus.m = ~vv.m;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.done && n < 20);
    check({tag, " latency"}, n, 32'd4);
    check({tag, " result"}, {16'd0, bus.result}, {16'd0, vv.res});
    check({tag, " cout"}, {31'd0, bus.cout}, {31'd0, vv.cout});
`ifdef ADDSUB_VFLAG_EN
    check({tag, " v"}, {31'd0, bus.v}, {31'd0, vv.v});
`endif
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, {31'd0, bus.done}, 32'd0);
    check({tag, " ready_back"}, {31'd0, bus.ready}, 32'd1);
    check({tag, " result_held"}, {16'd0, bus.result}, {16'd0, vv.res});
  endtask

  initial begin
    logic [W-1:0] qa [$];
    logic [W-1:0] qb [$];
    logic         qm [$];
    logic [W-1:0] ea, eb, er;
    logic         em, ec, ev;
    logic [W:0]   wide;
    int           dones;
    int           nodone;

    checks = 0;
    errors = 0;
    vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 16'h0001, 16'h000A, 16'hFFF7, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 16'h5555, 16'h5555, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

    bus.start = 1'b0;
    bus.m = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;
    #12;
    check("rst ready", {31'd0, bus.ready}, 32'd1);
    check("rst done", {31'd0, bus.done}, 32'd0);
    check("rst result", {16'd0, bus.result}, 32'd0);
    check("rst cout", {31'd0, bus.cout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // start held high with fresh operands every cycle
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      bus.start = 1'b1;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      bus.m = 1'($urandom);
      if (bus.ready) begin
        qa.push_back(bus.a);
        qb.push_back(bus.b);
        qm.push_back(bus.m);
      end
      @(posedge clk); #1;
      if (bus.done) begin
        dones++;
        if (qa.size() == 0) begin
          check("held done_without_op", 32'd1, 32'd0);
        end else begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          em = qm.pop_front();
          if (em) begin
            er = ea - eb;
            ec = (ea >= eb);
            ev = (ea[W-1] != eb[W-1]) && (er[W-1] != ea[W-1]);
          end else begin
            wide = {1'b0, ea} + {1'b0, eb};
            er = wide[W-1:0];
            ec = wide[W];
            ev = (ea[W-1] == eb[W-1]) && (er[W-1] != ea[W-1]);
          end
          check("held result", {16'd0, bus.result}, {16'd0, er});
          check("held cout", {31'd0, bus.cout}, {31'd0, ec});
`ifdef ADDSUB_VFLAG_EN
          check("held v", {31'd0, bus.v}, {31'd0, ev});
`endif
        end
      end
    end
    bus.start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        dones++;
        if (qa.size() == 0) begin
          check("held done_without_op", 32'd1, 32'd0);
        end else begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          em = qm.pop_front();
          if (em) begin
            er = ea - eb;
            ec = (ea >= eb);
          end else begin
            wide = {1'b0, ea} + {1'b0, eb};
            er = wide[W-1:0];
            ec = wide[W];
          end
          check("drain result", {16'd0, bus.result}, {16'd0, er});
          check("drain cout", {31'd0, bus.cout}, {31'd0, ec});
        end
      end
    end
    check("held done_count", dones, 32'd4);
    check("held pending", qa.size(), 32'd0);

    // reset while RUN at idx=2
    bus.start = 1'b1;
    bus.m = 1'b0;
    bus.a = 16'h1111;
    bus.b = 16'h1111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst ready", {31'd0, bus.ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("midrst ready", {31'd0, bus.ready}, 32'd1);
    check("midrst done", {31'd0, bus.done}, 32'd0);
    check("midrst result", {16'd0, bus.result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nodone = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.done) nodone++;
    end
    check("midrst no_done", nodone, 32'd0);
    run_op(vecs[0], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
